// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// Turns the 128x16 control-logic pROM into a per-T-state control word for the
// 8-bit CPU datapath. Every T-state is two clocks: S_ADDR presents the pROM
// address {opcode, t_state}, and S_EXEC exposes the registered pROM word as the
// live control word. The block also handles instruction end (step reset) and
// halt.
//
// Optional build macro: MICROSEQ_SINGLE_STEP_EN
//    When defined, adds step_btn_i. A T-state then advances only when run_i is
//    high and step_btn_i shows a rising edge, so one press executes exactly one
//    T-state.
//
// Parameters:
//    MAX_STEP  last legal step index (1..7); the step counter wraps to 0 after it
//    SR_BIT    control-word bit that ends the instruction early
//    HLT_BIT   control-word bit that halts the machine
//
// Ports:
//    clk_i       system clock, rising edge
//    reset_n_i   asynchronous active-low reset
//    run_i       sequencing enable, sampled only in S_ADDR
//    step_btn_i  (single-step build only) debounced step button
//    opcode_i    instruction-register opcode
//    rom_dout_i  pROM data output
//    rom_ad_o    pROM address {opcode, t_state}
//    rom_ce_o    pROM clock enable
//    rom_oce_o   pROM output-register enable, tied high
//    rom_reset_o pROM synchronous reset
//    ctrl_word_o control word to the datapath, zero unless ctrl_valid_o
//    ctrl_valid_o control word is live this cycle
//    t_state_o   current step index
//    halted_o    machine stopped by HLT

module microcode_sequencer #(
   parameter int MAX_STEP = 5,
   parameter int SR_BIT   = 0,
   parameter int HLT_BIT  = 15
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        run_i,
`ifdef MICROSEQ_SINGLE_STEP_EN
   input  logic        step_btn_i,
`endif
   input  logic [3:0]  opcode_i,
   input  logic [15:0] rom_dout_i,
   output logic [6:0]  rom_ad_o,
   output logic        rom_ce_o,
   output logic        rom_oce_o,
   output logic        rom_reset_o,
   output logic [15:0] ctrl_word_o,
   output logic        ctrl_valid_o,
   output logic [2:0]  t_state_o,
   output logic        halted_o
);

   localparam logic [2:0] MaxStepL = 3'(MAX_STEP);

   typedef enum logic [1:0] {
      S_RESET,
      S_ADDR,
      S_EXEC,
      S_HALT
   } state_e;

   state_e     state_q;
   state_e     state_d;
   logic [2:0] t_state_q;
   logic [2:0] t_state_d;
   logic       advance;

`ifdef MICROSEQ_SINGLE_STEP_EN
   logic step_btn_q;

   // Previous button level, so a held button only counts once.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         step_btn_q <= 1'b0;
      end else begin
         step_btn_q <= step_btn_i;
      end
   end

   assign advance = run_i & step_btn_i & ~step_btn_q;
`else
   assign advance = run_i;
`endif

   // State and step counter registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_RESET;
         t_state_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         t_state_q <= t_state_d;
      end
   end

   // Next-state logic. HLT is checked before SR, so a word with both bits set
   // halts the machine and leaves t_state where it was.
   always_comb begin
      state_d   = state_q;
      t_state_d = t_state_q;
      case (state_q)
         S_RESET: begin
            state_d = S_ADDR;
         end
         S_ADDR: begin
            if (advance) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (rom_dout_i[HLT_BIT]) begin
               state_d = S_HALT;
            end else begin
               state_d = S_ADDR;
               if (rom_dout_i[SR_BIT] || (t_state_q == MaxStepL)) begin
                  t_state_d = 3'd0;
               end else begin
                  t_state_d = t_state_q + 3'd1;
               end
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // Outputs are decoded from the state register alone. The control word is
   // gated here, and rom_dout_i only changes on the edge that ends S_ADDR, so
   // no glitch reaches the datapath outside S_EXEC.
   always_comb begin
      rom_ce_o     = 1'b0;
      rom_reset_o  = 1'b0;
      ctrl_valid_o = 1'b0;
      ctrl_word_o  = 16'h0000;
      halted_o     = 1'b0;
      case (state_q)
         S_RESET: begin
            rom_reset_o = 1'b1;
         end
         S_ADDR: begin
            rom_ce_o = run_i;
         end
         S_EXEC: begin
            ctrl_valid_o = 1'b1;
            ctrl_word_o  = rom_dout_i;
         end
         S_HALT: begin
            halted_o = 1'b1;
         end
         default: begin
            rom_reset_o = 1'b1;
         end
      endcase
   end

   assign rom_ad_o  = {opcode_i, t_state_q};
   assign rom_oce_o = 1'b1;
   assign t_state_o = t_state_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer. A behavioural pROM with a one-cycle
// registered read feeds the sequencer. Expected cycle snapshots are queued as
// each directed step is driven, and they are popped and compared as the
// sequencer reaches them.

module tb_microcode_sequencer;

   logic        clk;
   logic        resetN;
   logic        run;
   logic [3:0]  opcode;
   logic [15:0] romDout;
   logic [6:0]  romAd;
   logic        romCe;
   logic        romOce;
   logic        romReset;
   logic [15:0] ctrlWord;
   logic        ctrlValid;
   logic [2:0]  tState;
   logic        halted;
`ifdef MICROSEQ_SINGLE_STEP_EN
   logic        stepBtn;
`endif

   logic [15:0] romMem [128];

   typedef struct {
      string       tag;
      logic        valid;
      logic [15:0] word;
      logic [2:0]  tState;
      logic [6:0]  romAd;
      logic        halted;
      logic        romCe;
      logic        romReset;
   } exp_t;

   exp_t expQ[$];
   int   errors = 0;
   int   checks = 0;

   microcode_sequencer #(
      .MAX_STEP(5),
      .SR_BIT  (0),
      .HLT_BIT (15)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (resetN),
      .run_i       (run),
`ifdef MICROSEQ_SINGLE_STEP_EN
      .step_btn_i  (stepBtn),
`endif
      .opcode_i    (opcode),
      .rom_dout_i  (romDout),
      .rom_ad_o    (romAd),
      .rom_ce_o    (romCe),
      .rom_oce_o   (romOce),
      .rom_reset_o (romReset),
      .ctrl_word_o (ctrlWord),
      .ctrl_valid_o(ctrlValid),
      .t_state_o   (tState),
      .halted_o    (halted)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pROM model: synchronous read with clock enable and synchronous reset.
   always_ff @(posedge clk) begin
      if (romReset) begin
         romDout <= 16'h0000;
      end else if (romCe) begin
         romDout <= romMem[romAd];
      end
   end

   // Microprogram contents. Most words are distinct and have bits 15 and 0
   // clear. Opcode 2 ends early at step 3 (SR only). Opcode 3 halts at step 2
   // with both HLT and SR set.
   function automatic logic [15:0] prog(input logic [3:0] op, input logic [2:0] s);
      if (op == 4'h2 && s == 3'd3) return 16'h0001;
      if (op == 4'h3 && s == 3'd2) return 16'h8001;
      return {1'b0, op, s, 8'hA4};
   endfunction

   task automatic pushExp(input string tag, input logic v, input logic [15:0] w,
                          input logic [2:0] t, input logic [3:0] op,
                          input logic h, input logic ce, input logic rr);
      exp_t e;
      e.tag      = tag;
      e.valid    = v;
      e.word     = w;
      e.tState   = t;
      e.romAd    = {op, t};
      e.halted   = h;
      e.romCe    = ce;
      e.romReset = rr;
      expQ.push_back(e);
   endtask

   task automatic expAddr(input string tag, input logic [3:0] op, input logic [2:0] t, input logic ce);
      pushExp(tag, 1'b0, 16'h0000, t, op, 1'b0, ce, 1'b0);
   endtask

   task automatic expExec(input string tag, input logic [3:0] op, input logic [2:0] t);
      pushExp(tag, 1'b1, prog(op, t), t, op, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expHalt(input string tag, input logic [3:0] op, input logic [2:0] t);
      pushExp(tag, 1'b0, 16'h0000, t, op, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic expReset(input string tag, input logic [3:0] op);
      pushExp(tag, 1'b0, 16'h0000, 3'd0, op, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic compareField(input string tag, input string name,
                               input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s.%s: observed=%h expected=%h", tag, name, obs, expv);
      end
   endtask

   // Pops the next expected snapshot and compares it. With atEdge set, the
   // sample is taken on the falling edge. Otherwise it is taken 1 unit after
   // the last input change, which is used for the asynchronous checks.
   task automatic checkOutput(input bit atEdge);
      exp_t e;
      if (atEdge) @(negedge clk);
      else #1;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard: observed=empty expected=entry");
      end else begin
         e = expQ.pop_front();
         compareField(e.tag, "ctrlValid", {15'd0, ctrlValid}, {15'd0, e.valid});
         compareField(e.tag, "ctrlWord",  ctrlWord,           e.word);
         compareField(e.tag, "tState",    {13'd0, tState},    {13'd0, e.tState});
         compareField(e.tag, "romAd",     {9'd0, romAd},      {9'd0, e.romAd});
         compareField(e.tag, "halted",    {15'd0, halted},    {15'd0, e.halted});
         compareField(e.tag, "romCe",     {15'd0, romCe},     {15'd0, e.romCe});
         compareField(e.tag, "romReset",  {15'd0, romReset},  {15'd0, e.romReset});
         compareField(e.tag, "romOce",    {15'd0, romOce},    16'd1);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] op);
      run    = r;
      opcode = op;
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int a = 0; a < 128; a++) romMem[a] = prog(4'(a >> 3), 3'(a));
      resetN = 1'b0;
      applyStimulus(1'b0, 4'h0);
`ifdef MICROSEQ_SINGLE_STEP_EN
      stepBtn = 1'b0;
`endif

      // Reset state, then one S_RESET cycle after release.
      expReset("rstHeld", 4'h0);
      checkOutput(1);
      @(posedge clk); #1;
      resetN = 1'b1;
      applyStimulus(1'b1, 4'h0);
      expReset("rstRel", 4'h0);
      checkOutput(1);

`ifdef MICROSEQ_SINGLE_STEP_EN
      // Held button gives exactly one T-state. Separate pulses each give one.
      expAddr("ssIdle", 4'h0, 3'd0, 1'b1); checkOutput(1);
      expAddr("ssIdle", 4'h0, 3'd0, 1'b1); checkOutput(1);
      stepBtn = 1'b1;
      expExec("ssHeldE", 4'h0, 3'd0); checkOutput(1);
      for (int i = 0; i < 19; i++) begin
         expAddr("ssHeldA", 4'h0, 3'd1, 1'b1); checkOutput(1);
      end
      stepBtn = 1'b0;
      expAddr("ssRel", 4'h0, 3'd1, 1'b1); checkOutput(1);
      expAddr("ssRel", 4'h0, 3'd1, 1'b1); checkOutput(1);
      for (int k = 1; k <= 2; k++) begin
         stepBtn = 1'b1;
         expExec("ssPulseE", 4'h0, 3'(k)); checkOutput(1);
         stepBtn = 1'b0;
         expAddr("ssPulseA", 4'h0, 3'(k + 1), 1'b1); checkOutput(1);
      end
      expAddr("ssFinal", 4'h0, 3'd3, 1'b1); checkOutput(1);
`else
      // Full walk through opcode 0, with a wrap after MAX_STEP.
      for (int i = 0; i <= 5; i++) begin
         expAddr("seqA", 4'h0, 3'(i), 1'b1); checkOutput(1);
         expExec("seqE", 4'h0, 3'(i));       checkOutput(1);
      end
      expAddr("seqWrap", 4'h0, 3'd0, 1'b1); checkOutput(1);

      // Opcode 2 ends early at step 3. The IR changes while in S_ADDR.
      applyStimulus(1'b1, 4'h2);
      expExec("srE", 4'h2, 3'd0); checkOutput(1);
      for (int i = 1; i <= 3; i++) begin
         expAddr("srA", 4'h2, 3'(i), 1'b1); checkOutput(1);
         expExec("srE", 4'h2, 3'(i));       checkOutput(1);
      end
      expAddr("srNext", 4'h2, 3'd0, 1'b1); checkOutput(1);

      // Opcode 3 hits HLT+SR at step 2. HLT wins, so t_state stays at 2.
      applyStimulus(1'b1, 4'h3);
      expExec("hltE", 4'h3, 3'd0); checkOutput(1);
      for (int i = 1; i <= 2; i++) begin
         expAddr("hltA", 4'h3, 3'(i), 1'b1); checkOutput(1);
         expExec("hltE", 4'h3, 3'(i));       checkOutput(1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], 4'h3);
         expHalt("halt", 4'h3, 3'd2); checkOutput(1);
      end

      // Asynchronous reset out of halt.
      resetN = 1'b0;
      expReset("asyncHalt", 4'h3); checkOutput(0);
      applyStimulus(1'b1, 4'h1);
      @(posedge clk); #1;
      resetN = 1'b1;
      expReset("rstRel2", 4'h1); checkOutput(1);

      // Stall at step 1 with run low. run drops during EXEC, which still
      // lasts only one cycle.
      expAddr("stallA", 4'h1, 3'd0, 1'b1); checkOutput(1);
      expExec("stallE", 4'h1, 3'd0);       checkOutput(1);
      applyStimulus(1'b0, 4'h1);
      for (int i = 0; i < 10; i++) begin
         expAddr("stallHold", 4'h1, 3'd1, 1'b0); checkOutput(1);
      end
      applyStimulus(1'b1, 4'h1);
      expAddr("stallGo", 4'h1, 3'd1, 1'b1); checkOutput(0);
      expExec("resumeE", 4'h1, 3'd1);       checkOutput(1);
      for (int i = 2; i <= 4; i++) begin
         expAddr("midA", 4'h1, 3'(i), 1'b1); checkOutput(1);
         expExec("midE", 4'h1, 3'(i));       checkOutput(1);
      end

      // Asynchronous reset during EXEC at step 4 abandons the instruction.
      resetN = 1'b0;
      expReset("asyncExec", 4'h1); checkOutput(0);
      @(posedge clk); #1;
      resetN = 1'b1;
      expReset("rstRel3", 4'h1);            checkOutput(1);
      expAddr("restartA", 4'h1, 3'd0, 1'b1); checkOutput(1);
      expExec("restartE", 4'h1, 3'd0);       checkOutput(1);
`endif

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL leftover: observed=%0d expected=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Drives the 128×16 control-logic pROM (address = {opcode[3:0], step[2:0]}) and turns it into a per-T-state control word for the 8-bit CPU datapath. Owns the T-state counter, the pROM's one-cycle synchronous read latency, instruction end (step reset) and halt. It sits between the instruction register and every datapath register/bus enable.

## Interface
- MAX_STEP, 5: last legal step index; after executing this step the counter returns to 0 unconditionally (range 1..7).
- SR_BIT, 0: control-word bit that ends the instruction early (step reset).
- HLT_BIT, 15: control-word bit that halts the machine.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  sequencing enable; sampled only in S_ADDR.
- opcode  in  4  current instruction-register opcode.
- rom_dout  in  16  pROM data output.
- rom_ad  out  7  pROM address, {opcode, t_state}, combinational.
- rom_ce  out  1  pROM clock enable.
- rom_oce  out  1  pROM output-register enable, constant 1.
- rom_reset  out  1  pROM synchronous reset.
- ctrl_word  out  16  control word to datapath; all-zero when not valid.
- ctrl_valid  out  1  ctrl_word is live this cycle.
- t_state  out  3  current step index.
- halted  out  1  machine stopped by HLT.

## Operation
- States: S_RESET, S_ADDR, S_EXEC, S_HALT. Each T-state costs exactly one S_ADDR plus one S_EXEC cycle.
- Reset values: state S_RESET, t_state 0, halted 0, ctrl_valid 0, ctrl_word 0, rom_ce 0, rom_reset 1, rom_oce 1.
- S_RESET: rom_reset=1, rom_ce=0. Next state is S_ADDR unconditionally (one cycle).
- S_ADDR: rom_ad={opcode,t_state}; rom_ce=run. If run=1 go to S_EXEC, else stay (t_state frozen, ctrl_word 0).
- S_EXEC: ctrl_valid=1, ctrl_word=rom_dout, rom_ce=0. Datapath acts on the clk edge ending this cycle. Always lasts one cycle regardless of run.
  - rom_dout[HLT_BIT]=1: go to S_HALT, t_state unchanged.
  - else rom_dout[SR_BIT]=1 or t_state==MAX_STEP: t_state←0, go to S_ADDR.
  - else t_state←t_state+1, go to S_ADDR.
- HLT has priority over SR when both are set.
- S_HALT: halted=1, ctrl_word 0, ctrl_valid 0, rom_ce 0. Exits only via reset_n.
- opcode is sampled by the pROM at the edge ending S_ADDR, so an IR load in step N affects the address of step N+1.
- reset_n asserted in any state (mid-instruction included) immediately forces all reset values; any partial instruction is abandoned.

## Timing
- Address-to-control latency is one cycle: the address is presented in S_ADDR and ctrl_word is valid in the following S_EXEC.
- Minimum instruction time is 2×(steps executed) clk cycles.
- ctrl_word is combinationally gated by the state register. No glitch reaches the datapath outside S_EXEC because rom_dout only changes on the edge ending S_ADDR.
- Once reset_n is deasserted, the first ctrl_valid occurs no earlier than cycle 3: S_RESET, then S_ADDR, then S_EXEC.

## Configuration
- MICROSEQ_SINGLE_STEP_EN defined: adds input step_btn (1 bit, synchronous, already debounced). The S_ADDR→S_EXEC transition then requires run=1 and a rising edge of step_btn, detected by an internal registered previous value. Exactly one T-state executes per press. Holding the button high does not repeat.
- MICROSEQ_SINGLE_STEP_EN undefined: no step_btn port; run alone gates advancement.

## Test plan
- Reset then run=1, opcode=0, rom model returning 0x0000: t_state sequence 0,1,2,3,4,5,0 across 12 cycles of S_ADDR/S_EXEC pairs; rom_ad=0x00..0x05; ctrl_valid pulses on every second cycle.
- opcode=4'h2, step 3 word 0x0001 (SR set): after step 3 EXEC, t_state=0; rom_ad next=0x10.
- Word 0x8001 (HLT and SR) at step 2: halted=1 the next cycle; t_state stays 2; ctrl_word=0 forever until reset_n low.
- run=0 held for 10 cycles in S_ADDR at step 1: rom_ce=0, ctrl_valid=0, t_state=1. run=1 resumes with ctrl_word equal to the step-1 word.
- Assert reset_n low during S_EXEC at step 4: ctrl_word=0, t_state=0, rom_reset=1 asynchronously. After release, the first valid word is step 0.
- With MICROSEQ_SINGLE_STEP_EN, run=1, step_btn held high for 20 cycles: exactly one T-state executes. Three separate pulses give t_state 0→1→2→3.
